// File: rtl/pixel_fetch_if.sv
// Bundle of scan-controller, frame-RAM and LED-output signals around pixel_fetch.
// The slave modport is the fetch stage; the master modport is its environment.
interface pixel_fetch_if #(
  parameter int ROW_WIDTH  = 4,
  parameter int COL_WIDTH  = 6,
  parameter int CHAN_WIDTH = 6
);
  logic                               pixel_load_en;
  logic [COL_WIDTH-1:0]               column_address;
  logic [ROW_WIDTH-1:0]               row_address;
  logic [CHAN_WIDTH-1:0]              brightness_mask;
  logic                               swap_request;
  logic                               swap_ack;
  logic                               display_bank;
  logic                               ram_rd_en;
  logic [ROW_WIDTH+COL_WIDTH:0]       ram_addr;
  logic [6*CHAN_WIDTH-1:0]            ram_rd_data;
  logic [2:0]                         rgb_top;
  logic [2:0]                         rgb_bottom;
  logic                               pixel_valid;
  logic                               mask_error;

  modport slave (
    input  pixel_load_en, column_address, row_address, brightness_mask,
           swap_request, ram_rd_data,
    output swap_ack, display_bank, ram_rd_en, ram_addr,
           rgb_top, rgb_bottom, pixel_valid, mask_error
  );

  modport master (
    output pixel_load_en, column_address, row_address, brightness_mask,
           swap_request, ram_rd_data,
    input  swap_ack, display_bank, ram_rd_en, ram_addr,
           rgb_top, rgb_bottom, pixel_valid, mask_error
  );
endinterface

// File: rtl/pixel_fetch.sv
// Three-stage pixel fetch: issue RAM read, wait for data, reduce colour channels
// to one bit with the brightness bit-plane mask. Also owns frame-buffer bank swap.
module pixel_fetch #(
  parameter int ROW_WIDTH  = 4,
  parameter int COL_WIDTH  = 6,
  parameter int CHAN_WIDTH = 6
) (
  input  logic          clk_in,
  input  logic          reset,
  pixel_fetch_if.slave  pf
);

  localparam int AW = 1 + ROW_WIDTH + COL_WIDTH;
  localparam logic [CHAN_WIDTH-1:0] FRAME_MASK = {1'b1, {(CHAN_WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  function automatic logic [2:0] plane_bits(input logic [3*CHAN_WIDTH-1:0] chans,
                                            input logic [CHAN_WIDTH-1:0]   mask);
    plane_bits = {|(chans[3*CHAN_WIDTH-1:2*CHAN_WIDTH] & mask),
                  |(chans[2*CHAN_WIDTH-1:CHAN_WIDTH]   & mask),
                  |(chans[CHAN_WIDTH-1:0]              & mask)};
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_display_bank;
  logic                  r_swap_ack;
  logic                  r_mask_error;
  logic                  w_frame_start;
  logic                  w_swap_now;
  logic                  w_bank;
  logic                  w_mask_ok;

  logic                  r_vld_p1;
  logic [AW-1:0]         r_ram_addr_p1;
  logic [CHAN_WIDTH-1:0] r_mask_p1;
  logic                  r_bad_p1;

  logic                  r_vld_p2;
  logic [CHAN_WIDTH-1:0] r_mask_p2;
  logic                  r_bad_p2;

  logic                  r_vld_p3;
  logic [2:0]            r_rgb_top_p3;
  logic [2:0]            r_rgb_bottom_p3;

  assign w_mask_ok     = $onehot(pf.brightness_mask);
  assign w_frame_start = pf.pixel_load_en && (pf.row_address == '0) &&
                         (pf.column_address == '1) && (pf.brightness_mask == FRAME_MASK);
  // A request arriving with the frame-start strobe itself swaps immediately.
  assign w_swap_now    = w_frame_start && ((r_state == ST_PENDING) || pf.swap_request);
  assign w_bank        = r_display_bank ^ w_swap_now;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (pf.swap_request && !w_swap_now) w_state_nxt = ST_PENDING;
      ST_PENDING: if (w_swap_now) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_display_bank <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_mask_error   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_display_bank <= w_bank;
      r_swap_ack     <= w_swap_now;
      if (pf.pixel_load_en && !w_mask_ok) r_mask_error <= 1'b1;
    end
  end

  // Stage 1: issue the RAM read at {bank, row, column}
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_ram_addr_p1 <= '0;
    end else begin
      r_vld_p1 <= pf.pixel_load_en;
      if (pf.pixel_load_en)
        r_ram_addr_p1 <= {w_bank, pf.row_address, pf.column_address};
    end
  end

  always_ff @(posedge clk_in) begin
    r_mask_p1 <= pf.brightness_mask;
    r_bad_p1  <= !w_mask_ok;
    r_mask_p2 <= r_mask_p1;
    r_bad_p2  <= r_bad_p1;
  end

  // Stage 2: RAM access in flight
  always_ff @(posedge clk_in) begin
    if (reset) r_vld_p2 <= 1'b0;
    else       r_vld_p2 <= r_vld_p1;
  end

  // Stage 3: bit-plane select; outputs hold between valid pulses
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_vld_p3        <= 1'b0;
      r_rgb_top_p3    <= 3'b000;
      r_rgb_bottom_p3 <= 3'b000;
    end else begin
      r_vld_p3 <= r_vld_p2;
      if (r_vld_p2) begin
        if (r_bad_p2) begin
          r_rgb_top_p3    <= 3'b000;
          r_rgb_bottom_p3 <= 3'b000;
        end else begin
          r_rgb_top_p3    <= plane_bits(pf.ram_rd_data[6*CHAN_WIDTH-1:3*CHAN_WIDTH], r_mask_p2);
          r_rgb_bottom_p3 <= plane_bits(pf.ram_rd_data[3*CHAN_WIDTH-1:0], r_mask_p2);
        end
      end
    end
  end

  assign pf.ram_rd_en    = r_vld_p1;
  assign pf.ram_addr     = r_ram_addr_p1;
  assign pf.rgb_top      = r_rgb_top_p3;
  assign pf.rgb_bottom   = r_rgb_bottom_p3;
  assign pf.pixel_valid  = r_vld_p3;
  assign pf.swap_ack     = r_swap_ack;
  assign pf.display_bank = r_display_bank;
  assign pf.mask_error   = r_mask_error;

endmodule
